// File: rtl/regfile_bypass_sb_pkg.sv
// Shared types for the bypassing register file: clear-sequencer states and depth helper.
package regfile_bypass_sb_pkg;

  typedef enum logic {
    StClear = 1'b0,
    StReady = 1'b1
  } state_e;

  function automatic int unsigned depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_bypass_sb_if.sv
// Decode/writeback-facing bundle of the register file: read ports, write port, scoreboard, clear.
interface regfile_bypass_sb_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
);

  logic              clear;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              busy_set;
  logic [ADDR_W-1:0] busy_set_reg;
  logic              busy1;
  logic              busy2;

  modport master (
    output clear, we, write_reg, write_data, read_reg1, read_reg2, busy_set, busy_set_reg,
    input  ready, read_data1, read_data2, busy1, busy2
  );

  modport slave (
    input  clear, we, write_reg, write_data, read_reg1, read_reg2, busy_set, busy_set_reg,
    output ready, read_data1, read_data2, busy1, busy2
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for the issue stage; a new producer (set) supersedes a retiring one.
module regfile_scoreboard
  import regfile_bypass_sb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_reg_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_reg_i,
  input  logic [ADDR_W-1:0] rd_reg1_i,
  input  logic [ADDR_W-1:0] rd_reg2_i,
  output logic              busy1_o,
  output logic              busy2_o
);

  localparam int unsigned Depth = depth(ADDR_W);

  logic [Depth-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_reg_i] = 1'b0;
    // Applied after the clear so a same-index set wins.
    if (set_i) busy_d[set_reg_i] = 1'b1;
    if (flush_i) busy_d = '0;
    if (ZERO_REG) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy1_o = busy_q[rd_reg1_i];
  assign busy2_o = busy_q[rd_reg2_i];

endmodule

// File: rtl/regfile_bypass_sb.sv
// Register file with optional zero register, write-to-read bypass, clear sequencer and scoreboard.
module regfile_bypass_sb
  import regfile_bypass_sb_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input logic               clk,
  input logic               rst,
  regfile_bypass_sb_if.slave bus
);

  localparam int unsigned       Depth   = depth(ADDR_W);
  localparam logic [ADDR_W:0]   LastIdx = (ADDR_W + 1)'(Depth - 1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0] regs_q [Depth];
  logic              ready;
  logic              wr_en;
  logic              flush;
  logic              sb_busy1, sb_busy2;

  assign ready = (state_q == StReady);
  assign wr_en = ready && bus.we && !(ZERO_REG && (bus.write_reg == '0));

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    flush     = 1'b0;
    unique case (state_q)
      StClear: begin
        clr_idx_d = clr_idx_q + (ADDR_W + 1)'(1);
        if (clr_idx_q == LastIdx) begin
          state_d   = StReady;
          clr_idx_d = '0;
        end
      end
      StReady: begin
        if (bus.clear) begin
          state_d   = StClear;
          clr_idx_d = '0;
          flush     = 1'b1;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Storage has no reset; the clear sequence defines its content.
  always_ff @(posedge clk) begin
    if (!ready) begin
      regs_q[clr_idx_q[ADDR_W-1:0]] <= '0;
    end else if (wr_en) begin
      regs_q[bus.write_reg] <= bus.write_data;
    end
  end

  always_comb begin
    bus.read_data1 = regs_q[bus.read_reg1];
    bus.read_data2 = regs_q[bus.read_reg2];
    if (BYPASS && wr_en && (bus.write_reg == bus.read_reg1)) bus.read_data1 = bus.write_data;
    if (BYPASS && wr_en && (bus.write_reg == bus.read_reg2)) bus.read_data2 = bus.write_data;
    if (ZERO_REG && (bus.read_reg1 == '0)) bus.read_data1 = '0;
    if (ZERO_REG && (bus.read_reg2 == '0)) bus.read_data2 = '0;
    if (!ready) begin
      bus.read_data1 = '0;
      bus.read_data2 = '0;
    end
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk_i    (clk),
    .rst_i    (rst),
    .flush_i  (flush),
    .set_i    (ready && bus.busy_set),
    .set_reg_i(bus.busy_set_reg),
    .clr_i    (ready && bus.we),
    .clr_reg_i(bus.write_reg),
    .rd_reg1_i(bus.read_reg1),
    .rd_reg2_i(bus.read_reg2),
    .busy1_o  (sb_busy1),
    .busy2_o  (sb_busy2)
  );

  assign bus.ready = ready;
  assign bus.busy1 = ready && sb_busy1;
  assign bus.busy2 = ready && sb_busy2;

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Randomised bench for regfile_bypass_sb: two configurations checked against an array model.
module tb_regfile_bypass_sb;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 5;
  localparam int unsigned N  = 32;
  localparam int unsigned ClearCycles = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  regfile_bypass_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  regfile_bypass_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus_nb ();

  // Second instance: no zero register, no bypass, same stimulus.
  assign bus_nb.clear        = bus.clear;
  assign bus_nb.we           = bus.we;
  assign bus_nb.write_reg    = bus.write_reg;
  assign bus_nb.write_data   = bus.write_data;
  assign bus_nb.read_reg1    = bus.read_reg1;
  assign bus_nb.read_reg2    = bus.read_reg2;
  assign bus_nb.busy_set     = bus.busy_set;
  assign bus_nb.busy_set_reg = bus.busy_set_reg;

  regfile_bypass_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  regfile_bypass_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut_nb (
    .clk(clk),
    .rst(rst),
    .bus(bus_nb)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit             zr [2] = '{1'b1, 1'b0};
  bit             bp [2] = '{1'b1, 1'b0};
  logic [DW-1:0]  m_regs [2][N];
  bit             m_busy [2][N];
  int             m_left;

  function automatic void model_reset();
    m_left = ClearCycles;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < N; i++) begin
        m_regs[c][i] = '0;
        m_busy[c][i] = 1'b0;
      end
  endfunction

  function automatic void model_step();
    if (m_left > 0) begin
      m_left--;
      return;
    end
    for (int c = 0; c < 2; c++) begin
      if (bus.we && !(zr[c] && bus.write_reg == 0)) m_regs[c][bus.write_reg] = bus.write_data;
      if (bus.we) m_busy[c][bus.write_reg] = 1'b0;
      if (bus.busy_set) m_busy[c][bus.busy_set_reg] = 1'b1;
      if (zr[c]) m_busy[c][0] = 1'b0;
      if (bus.clear)
        for (int i = 0; i < N; i++) begin
          m_regs[c][i] = '0;
          m_busy[c][i] = 1'b0;
        end
    end
    if (bus.clear) m_left = ClearCycles;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int c, input logic [AW-1:0] idx);
    if (m_left > 0) return '0;
    if (zr[c] && idx == 0) return '0;
    if (bp[c] && bus.we && bus.write_reg == idx) return bus.write_data;
    return m_regs[c][idx];
  endfunction

  function automatic logic exp_busy(input int c, input logic [AW-1:0] idx);
    if (m_left > 0) return 1'b0;
    return m_busy[c][idx];
  endfunction

  // Compare process: inputs change just after negedge, outputs checked 2 time units later.
  always begin
    @(negedge clk);
    #2;
    if (rst) model_reset();
    chk("ready", 32'(bus.ready), 32'(m_left == 0));
    chk("rd1", 32'(bus.read_data1), 32'(exp_rd(0, bus.read_reg1)));
    chk("rd2", 32'(bus.read_data2), 32'(exp_rd(0, bus.read_reg2)));
    chk("busy1", 32'(bus.busy1), 32'(exp_busy(0, bus.read_reg1)));
    chk("busy2", 32'(bus.busy2), 32'(exp_busy(0, bus.read_reg2)));
    chk("nb_ready", 32'(bus_nb.ready), 32'(m_left == 0));
    chk("nb_rd1", 32'(bus_nb.read_data1), 32'(exp_rd(1, bus.read_reg1)));
    chk("nb_rd2", 32'(bus_nb.read_data2), 32'(exp_rd(1, bus.read_reg2)));
    chk("nb_busy1", 32'(bus_nb.busy1), 32'(exp_busy(1, bus.read_reg1)));
    chk("nb_busy2", 32'(bus_nb.busy2), 32'(exp_busy(1, bus.read_reg2)));
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.clear    = 1'b0;
    bus.we       = 1'b0;
    bus.busy_set = 1'b0;
  endtask

  task automatic count_to_ready(output int cnt);
    cnt = 0;
    while (!bus.ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  function automatic logic [AW-1:0] rnd_idx();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, N - 1));
  endfunction

  initial begin
    int cnt;
    bus.clear = 1'b0; bus.we = 1'b0; bus.write_reg = '0; bus.write_data = '0;
    bus.read_reg1 = '0; bus.read_reg2 = '0; bus.busy_set = 1'b0; bus.busy_set_reg = '0;
    model_reset();

    // Reset release: exactly 32 cycles of clear.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_to_ready(cnt);
    chk("reset_clear_len", 32'(cnt), 32'd32);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      bus.read_reg1 = AW'(i);
      bus.read_reg2 = AW'(N - 1 - i);
      #3;
      chk("post_reset_rd1", 32'(bus.read_data1), 32'h0);
      chk("post_reset_rd2", 32'(bus.read_data2), 32'h0);
    end

    // Bypass on write to reg 5.
    @(negedge clk);
    bus.we = 1'b1; bus.write_reg = 5'd5; bus.write_data = 16'hBEEF;
    bus.read_reg1 = 5'd5; bus.read_reg2 = 5'd5;
    #3;
    chk("bypass_rd1", 32'(bus.read_data1), 32'hBEEF);
    chk("nobypass_rd1_old", 32'(bus_nb.read_data1), 32'h0);
    @(negedge clk);
    idle();
    #3;
    chk("reg5_after", 32'(bus.read_data1), 32'hBEEF);
    chk("nb_reg5_after", 32'(bus_nb.read_data2), 32'hBEEF);

    // Zero register ignores writes and busy_set.
    @(negedge clk);
    bus.we = 1'b1; bus.write_reg = 5'd0; bus.write_data = 16'h1234;
    bus.busy_set = 1'b1; bus.busy_set_reg = 5'd0; bus.read_reg1 = 5'd0;
    #3;
    chk("zero_rd_same", 32'(bus.read_data1), 32'h0);
    @(negedge clk);
    idle();
    #3;
    chk("zero_rd_after", 32'(bus.read_data1), 32'h0);
    chk("zero_busy", 32'(bus.busy1), 32'h0);
    chk("nb_reg0_written", 32'(bus_nb.read_data1), 32'h1234);

    // Busy set then retire; then simultaneous set and retire.
    @(negedge clk);
    bus.busy_set = 1'b1; bus.busy_set_reg = 5'd7; bus.read_reg1 = 5'd7;
    #3;
    chk("busy7_no_bypass", 32'(bus.busy1), 32'h0);
    @(negedge clk);
    bus.busy_set = 1'b0; bus.we = 1'b1; bus.write_reg = 5'd7; bus.write_data = 16'h0707;
    #3;
    chk("busy7_set", 32'(bus.busy1), 32'h1);
    @(negedge clk);
    idle();
    #3;
    chk("busy7_retired", 32'(bus.busy1), 32'h0);
    @(negedge clk);
    bus.busy_set = 1'b1; bus.busy_set_reg = 5'd7;
    bus.we = 1'b1; bus.write_reg = 5'd7; bus.write_data = 16'h7777;
    @(negedge clk);
    idle();
    #3;
    chk("busy7_set_wins", 32'(bus.busy1), 32'h1);
    chk("reg7_written", 32'(bus.read_data1), 32'h7777);

    // Clear sequence after writing reg 3.
    @(negedge clk);
    bus.we = 1'b1; bus.write_reg = 5'd3; bus.write_data = 16'hAAAA; bus.read_reg1 = 5'd3;
    @(negedge clk);
    idle();
    #3;
    chk("reg3_written", 32'(bus.read_data1), 32'hAAAA);
    @(negedge clk);
    bus.clear = 1'b1;
    #3;
    chk("ready_before_clear", 32'(bus.ready), 32'h1);
    @(negedge clk);
    bus.clear = 1'b0;
    cnt = 0;
    while (!bus.ready && cnt < 100) begin
      bus.we = 1'b1; bus.write_reg = 5'd3; bus.write_data = 16'h5555;
      bus.busy_set = 1'b1; bus.busy_set_reg = 5'd3;
      #3;
      chk("clear_rd_zero", 32'(bus.read_data1), 32'h0);
      chk("clear_busy_zero", 32'(bus.busy1), 32'h0);
      cnt++;
      @(negedge clk);
    end
    idle();
    #3;
    chk("clear_len", 32'(cnt), 32'd32);
    chk("reg3_cleared", 32'(bus.read_data1), 32'h0);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      bus.read_reg1 = AW'(i);
      #3;
      chk("busy_cleared", 32'(bus.busy1), 32'h0);
      chk("nb_busy_cleared", 32'(bus_nb.busy1), 32'h0);
    end

    // Reset in the middle of a clear restarts the sequence.
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    idle();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #3;
    chk("ready_in_rst", 32'(bus.ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    count_to_ready(cnt);
    chk("rst_mid_clear_len", 32'(cnt), 32'd32);

    // Random traffic, checked every cycle by the compare process.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 799) == 0);
      bus.clear        = ($urandom_range(0, 149) == 0);
      bus.we           = ($urandom_range(0, 1) == 1);
      bus.write_reg    = rnd_idx();
      bus.write_data   = DW'($urandom);
      bus.read_reg1    = rnd_idx();
      bus.read_reg2    = ($urandom_range(0, 7) == 0) ? bus.read_reg1 : rnd_idx();
      bus.busy_set     = ($urandom_range(0, 2) == 0);
      bus.busy_set_reg = ($urandom_range(0, 3) == 0) ? bus.write_reg : rnd_idx();
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
- Next-generation CPU register file: parametrised width and depth, two asynchronous read ports, one synchronous write port.
- Adds optional hardwired zero register, write-to-read bypass, a hardware clear sequencer, and a per-register busy scoreboard for the issue stage.
- Sits between decode (read ports, busy lookup, busy set) and writeback (write port, busy clear).

Parameters:
DATA_W, 16, data width of each register
ADDR_W, 5, register index width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy
BYPASS, 1, 1 = same-cycle write data forwarded to matching read port

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
clear  in  1  request a full clear sequence; sampled only in READY
ready  out  1  1 = file usable; 0 during clear sequence
we  in  1  write enable
write_reg  in  ADDR_W  write index
write_data  in  DATA_W  write data
read_reg1  in  ADDR_W  read port 1 index
read_reg2  in  ADDR_W  read port 2 index
read_data1  out  DATA_W  read port 1 data (combinational)
read_data2  out  DATA_W  read port 2 data (combinational)
busy_set  in  1  mark busy_set_reg as having an outstanding producer
busy_set_reg  in  ADDR_W  index to mark busy
busy1  out  1  scoreboard bit of read_reg1 (combinational)
busy2  out  1  scoreboard bit of read_reg2 (combinational)

Behaviour:
- FSM states CLEAR and READY. rst asserted forces CLEAR asynchronously: clr_idx=0, all busy bits=0, ready=0.
- CLEAR: each cycle writes 0 to regs[clr_idx] and increments clr_idx. When clr_idx = 2**ADDR_W-1 is written, next state is READY. ready rises 2**ADDR_W cycles after rst deasserts.
- READY with clear=1: next state CLEAR, clr_idx=0, busy bits=0. Any write in that same cycle is still performed, then overwritten by the clear.
- During CLEAR: we and busy_set ignored; read_data1/2 = 0; busy1/2 = 0.
- Write in READY: if we and not (ZERO_REG and write_reg==0), regs[write_reg] <= write_data at the clock edge.
- Read: read_dataN = regs[read_regN] combinationally.
  - If ZERO_REG and read_regN==0: 0.
  - Else if BYPASS and we and write_reg==read_regN: write_data.
  - The register array itself has no reset; content is defined only after the clear sequence.
- Scoreboard: one bit per register.
  - we clears bit[write_reg].
  - busy_set sets bit[busy_set_reg].
  - Same index in the same cycle: set wins, because the new producer supersedes the old one.
  - Different indices: both take effect.
  - With ZERO_REG, bit 0 is held at 0.
  - busyN reflects the registered bit only; there is no same-cycle bypass on busy.
- Both read ports may address the same register; the two outputs are identical.
- Wrap-around: clr_idx is ADDR_W+1 bits wide internally to detect the terminal count cleanly.

Decomposition:
- Shared package: FSM state enum (CLEAR, READY) and DEPTH = 2**ADDR_W as a localparam function.
- One natural sub-module, regfile_scoreboard, holding the busy bit vector with set/clear priority and zero-reg masking.
- Storage, bypass and the clear FSM stay in the top.

Test Plan:
- Reset then release: ready=0 for exactly 32 cycles (ADDR_W=5), then 1; read of every index returns 0x0000.
- Write reg 5 = 0xBEEF with read_reg1=5 in the same cycle: read_data1=0xBEEF combinationally (BYPASS=1). With BYPASS=0 it shows the old value 0x0000 until after the edge.
- Write reg 0 = 0x1234 with ZERO_REG=1: read_data1 stays 0x0000. busy_set on reg 0: busy1 stays 0.
- busy_set reg 7, then one cycle later we to reg 7: busy1(7) is 1 for one cycle, then 0. Simultaneous busy_set(7) and we(7): busy stays 1 and data is written.
- Pulse clear in READY after writing reg 3 = 0xAAAA: ready drops next cycle; reads are 0 and writes ignored for 32 cycles; afterwards reg 3 = 0x0000 and all busy bits = 0.
- Assert rst mid-clear at clr_idx=10: ready stays 0, the sequence restarts from index 0, and ready rises 32 cycles after release.
